// File: rtl/hilo_pkg.sv
// Shared definitions for the HI/LO sequencer: opcodes, FSM encoding and divider sizing.
package hilo_pkg;

    localparam logic [1:0] OP_MULT = 2'b00;
    localparam logic [1:0] OP_DIV  = 2'b01;
    localparam logic [1:0] OP_MTHI = 2'b10;
    localparam logic [1:0] OP_MTLO = 2'b11;

    localparam int unsigned DIV_CYCLES = 32;
    localparam int unsigned DIV_CNT_W  = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        StIdle,
        StMultWait,
        StDivRun,
        StFinish
    } state_e;

endpackage

// File: rtl/div32_iter.sv
// Unsigned restoring divider, one quotient bit per clock, MSB first.
module div32_iter
    import hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        last,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0]          rem_q;
    logic [31:0]          quo_q;
    logic [31:0]          dsr_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 run_q;

    logic [32:0] shifted;
    logic [32:0] diff;

    // quotient/remainder are the post-step values, so the caller can capture
    // them on the same edge that performs the final iteration.
    always_comb begin
        shifted   = {rem_q, quo_q[31]};
        diff      = shifted - {1'b0, dsr_q};
        quotient  = {quo_q[30:0], ~diff[32]};
        remainder = diff[32] ? shifted[31:0] : diff[31:0];
        last      = run_q && (cnt_q == DIV_CNT_W'(DIV_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= '0;
            quo_q <= '0;
            dsr_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dsr_q <= divisor;
            cnt_q <= '0;
            run_q <= 1'b1;
        end else if (run_q) begin
            rem_q <= remainder;
            quo_q <= quotient;
            cnt_q <= cnt_q + DIV_CNT_W'(1);
            if (last) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/hilo_unit.sv
// HI/LO sequencer: drives an external MULT32, runs the iterative divider and MTHI/MTLO.
module hilo_unit
    import hilo_pkg::*;
#(
    parameter int unsigned MULT_LATENCY = 1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [1:0]  OP,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [31:0] MULT_HI,
    input  logic [31:0] MULT_LO,
    output logic [31:0] MULT_A,
    output logic [31:0] MULT_B,
    output logic        BUSY,
    output logic        DONE,
    output logic        DIV_BY_ZERO,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        zero_q;
    logic        div_start;
    logic        div_last;
    logic [31:0] div_quo;
    logic [31:0] div_rem;

    // Divide-by-zero never enters the iterator; the FSM short-circuits it.
    assign div_start = START && (OP == OP_DIV) && (B != '0)
                       && ((state_q == StIdle) || (state_q == StFinish));

    div32_iter u_div (
        .clk       (CLK),
        .rst       (RST),
        .start     (div_start),
        .dividend  (A),
        .divisor   (B),
        .last      (div_last),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            zero_q      <= 1'b0;
            MULT_A      <= '0;
            MULT_B      <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            HI          <= '0;
            LO          <= '0;
        end else begin
            DONE <= 1'b0;
            unique case (state_q)
                StIdle, StFinish: begin
                    state_q <= StIdle;
                    BUSY    <= 1'b0;
                    if (START) begin
                        case (OP)
                            OP_MULT: begin
                                MULT_A      <= A;
                                MULT_B      <= B;
                                cnt_q       <= 4'(MULT_LATENCY);
                                state_q     <= StMultWait;
                                BUSY        <= 1'b1;
                                DIV_BY_ZERO <= 1'b0;
                            end
                            OP_DIV: begin
                                MULT_A      <= A;
                                MULT_B      <= B;
                                zero_q      <= (B == '0);
                                state_q     <= StDivRun;
                                BUSY        <= 1'b1;
                                DIV_BY_ZERO <= 1'b0;
                            end
                            OP_MTHI: HI <= A;
                            OP_MTLO: LO <= A;
                        endcase
                    end
                end
                StMultWait: begin
                    if (cnt_q == 4'd1) begin
                        HI      <= MULT_HI;
                        LO      <= MULT_LO;
                        state_q <= StFinish;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StDivRun: begin
                    if (zero_q) begin
                        LO          <= 32'hFFFF_FFFF;
                        HI          <= MULT_A;
                        DIV_BY_ZERO <= 1'b1;
                        state_q     <= StFinish;
                        BUSY        <= 1'b0;
                        DONE        <= 1'b1;
                    end else if (div_last) begin
                        LO      <= div_quo;
                        HI      <= div_rem;
                        state_q <= StFinish;
                        BUSY    <= 1'b0;
                        DONE    <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_unit.sv
// Self-checking bench for hilo_unit with a behavioural MULT32 and HI/LO reference model.
module tb_hilo_unit;
    import hilo_pkg::*;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic        START;
    logic [1:0]  OP;
    logic [31:0] A, B;
    logic [31:0] MULT_HI, MULT_LO, MULT_A, MULT_B;
    logic        BUSY, DONE, DIV_BY_ZERO;
    logic [31:0] HI, LO;
    logic [63:0] prod;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_hi, m_lo, m_a, m_b;
    logic        m_dbz;
    int          exp_lat;

    always #5 CLK = ~CLK;

    // External combinational MULT32.
    assign prod    = 64'(MULT_A) * 64'(MULT_B);
    assign MULT_HI = prod[63:32];
    assign MULT_LO = prod[31:0];

    hilo_unit #(.MULT_LATENCY(LAT)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .START       (START),
        .OP          (OP),
        .A           (A),
        .B           (B),
        .MULT_HI     (MULT_HI),
        .MULT_LO     (MULT_LO),
        .MULT_A      (MULT_A),
        .MULT_B      (MULT_B),
        .BUSY        (BUSY),
        .DONE        (DONE),
        .DIV_BY_ZERO (DIV_BY_ZERO),
        .HI          (HI),
        .LO          (LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        START = 1'b1; OP = op; A = a; B = b;
        @(posedge CLK);
        #1;
        START = 1'b0;
        case (op)
            OP_MULT: begin
                {m_hi, m_lo} = 64'(a) * 64'(b);
                m_a = a; m_b = b; m_dbz = 1'b0; exp_lat = LAT;
            end
            OP_DIV: begin
                m_a = a; m_b = b; m_dbz = (b == 0);
                if (b == 0) begin
                    m_lo = 32'hFFFF_FFFF; m_hi = a; exp_lat = 1;
                end else begin
                    m_lo = a / b; m_hi = a % b; exp_lat = 32;
                end
            end
            OP_MTHI: begin m_hi = a; exp_lat = 0; end
            default: begin m_lo = a; exp_lat = 0; end
        endcase
    endtask

    task automatic finish_op(input string tag);
        int n = 0;
        int busy_n = 0;
        if (exp_lat == 0) begin
            check({tag, "_busy"}, 64'(BUSY), 64'(0));
            check({tag, "_done"}, 64'(DONE), 64'(0));
        end else begin
            while (DONE !== 1'b1 && n < 64) begin
                if (BUSY === 1'b1) busy_n++;
                @(posedge CLK);
                #1;
                START = 1'b0;
                n++;
            end
            check({tag, "_lat"}, 64'(n), 64'(exp_lat));
            check({tag, "_busycyc"}, 64'(busy_n), 64'(exp_lat));
            check({tag, "_busy_fin"}, 64'(BUSY), 64'(0));
        end
        check({tag, "_hi"}, 64'(HI), 64'(m_hi));
        check({tag, "_lo"}, 64'(LO), 64'(m_lo));
        check({tag, "_dbz"}, 64'(DIV_BY_ZERO), 64'(m_dbz));
        check({tag, "_ma"}, 64'(MULT_A), 64'(m_a));
        check({tag, "_mb"}, 64'(MULT_B), 64'(m_b));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int pulses;
        logic [1:0]  r_op;
        logic [31:0] r_a, r_b;

        RST = 1'b1; START = 1'b0; OP = '0; A = '0; B = '0;
        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_dbz = 1'b0; exp_lat = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_hi", 64'(HI), 64'(0));
        check("rst_lo", 64'(LO), 64'(0));
        check("rst_busy", 64'(BUSY), 64'(0));
        check("rst_done", 64'(DONE), 64'(0));
        check("rst_dbz", 64'(DIV_BY_ZERO), 64'(0));
        check("rst_ma", 64'(MULT_A), 64'(0));
        RST = 1'b0;

        launch(OP_MULT, 32'd4, 32'd10);            finish_op("mul_4x10");
        launch(OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF); finish_op("mul_max");
        launch(OP_DIV, 32'd100, 32'd7);             finish_op("div_100_7");
        launch(OP_DIV, 32'd5, 32'd9);               finish_op("div_5_9");
        launch(OP_DIV, 32'h1234, 32'd0);            finish_op("div_by0");
        launch(OP_MULT, 32'd3, 32'd3);              finish_op("mul_3x3");

        // MTHI while the divider is busy must be dropped.
        launch(OP_DIV, 32'd100, 32'd7);
        START = 1'b1; OP = OP_MTHI; A = 32'hCAFE;
        finish_op("div_ign_mthi");
        launch(OP_MTLO, 32'hBEEF, 32'd0);           finish_op("mtlo");
        launch(OP_MTHI, 32'hCAFE, 32'd0);           finish_op("mthi");

        // Reset during a divide: result discarded, no DONE.
        launch(OP_DIV, 32'd100, 32'd7);
        repeat (9) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_dbz = 1'b0;
        check("midrst_hi", 64'(HI), 64'(0));
        check("midrst_lo", 64'(LO), 64'(0));
        check("midrst_busy", 64'(BUSY), 64'(0));
        pulses = 0;
        repeat (40) begin
            @(posedge CLK);
            #1;
            if (DONE === 1'b1) pulses++;
        end
        check("midrst_nodone", 64'(pulses), 64'(0));
        launch(OP_MULT, 32'd6, 32'd7);              finish_op("mul_after_rst");

        for (int i = 0; i < 40; i++) begin
            r_op = 2'($urandom_range(0, 3));
            r_a  = $urandom;
            if ($urandom_range(0, 3) == 0) r_a = $urandom_range(0, 50);
            case ($urandom_range(0, 7))
                0:       r_b = 32'd0;
                1, 2:    r_b = $urandom_range(1, 20);
                default: r_b = $urandom;
            endcase
            launch(r_op, r_a, r_b);
            finish_op("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
